// File: rtl/dffsr_seq_pkg.sv
// ---------------------------------------------------------------------------
// Module : dffsr_seq_pkg
// Brief  : Shared types and helpers for the dffsr RN/SN control sequencer.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

package dffsr_seq_pkg;

  typedef enum logic [2:0] {
    RST_HOLD = 3'd0,
    IDLE     = 3'd1,
    GATE     = 3'd2,
    PULSE    = 3'd3,
    RECOVER  = 3'd4
  } state_e;

  typedef enum logic {
    SET = 1'b0,
    CLR = 1'b1
  } kind_e;

  localparam int MIN_CYC = 1;

  // Bits needed to count 0 .. max(a,b)-1; never less than one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = (a > b) ? a : b;
    w = 1;
    while ((1 << w) < m) w = w + 1;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dffsr_seq_pend.sv
// ---------------------------------------------------------------------------
// Module : dffsr_seq_pend
// Brief  : One-deep pending request slot with clear dominance and drop detect.
//          Drop detect exists only when DFFSR_SEQ_STAT_EN is defined.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module dffsr_seq_pend
  import dffsr_seq_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  input  kind_e in_kind,
  input  logic  take,
  output logic  merged_valid,
  output kind_e merged_kind
`ifdef DFFSR_SEQ_STAT_EN
  ,
  output logic  drop
`endif
);

  logic  valid_q, valid_d;
  kind_e kind_q,  kind_d;
  logic  full_drop;

  // Merged view = slot contents plus this cycle's arrival, so a request that
  // lands on the consuming cycle is not delayed by a round trip through the slot.
  always_comb begin
    merged_valid = valid_q | in_valid;
    merged_kind  = in_kind;
    full_drop    = 1'b0;
    if (valid_q) begin
      merged_kind = kind_q;
      if (in_valid) begin
        if (kind_q == SET && in_kind == CLR) merged_kind = CLR;
        else                                 full_drop   = 1'b1;
      end
    end
    valid_d = take ? 1'b0 : merged_valid;
    kind_d  = merged_kind;
  end

`ifdef DFFSR_SEQ_STAT_EN
  assign drop = full_drop;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      kind_q  <= SET;
    end else begin
      valid_q <= valid_d;
      kind_q  <= kind_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dffsr_ctrl_seq.sv
// ---------------------------------------------------------------------------
// Module : dffsr_ctrl_seq
// Brief  : Drives RN/SN/CLK_EN of a dffsr flop bank with timed, clock-gated
//          pulses. Optional DROP_CNT statistics via DFFSR_SEQ_STAT_EN.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module dffsr_ctrl_seq
  import dffsr_seq_pkg::*;
#(
  parameter int WIDTH_CYC = 2,
  parameter int RECOV_CYC = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SET_REQ,
  input  logic       CLR_REQ,
  output logic       RN,
  output logic       SN,
  output logic       CLK_EN,
  output logic       BUSY,
  output logic       ACK
`ifdef DFFSR_SEQ_STAT_EN
  ,
  output logic [7:0] DROP_CNT
`endif
);

  localparam int W_CYC = (WIDTH_CYC < MIN_CYC) ? MIN_CYC : WIDTH_CYC;
  localparam int R_CYC = (RECOV_CYC < MIN_CYC) ? MIN_CYC : RECOV_CYC;
  localparam int CNT_W = cnt_width(W_CYC, R_CYC);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(W_CYC - 1);
  localparam logic [CNT_W-1:0] R_LAST = CNT_W'(R_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  kind_e            kind_q, kind_d;
  logic             serving_q, serving_d;
  logic             rn_q, rn_d, sn_q, sn_d, clk_en_q, clk_en_d;
  logic             busy_q, busy_d, ack_q, ack_d;

  logic             req_valid, take, merged_valid;
  kind_e            req_kind, merged_kind;

  assign req_valid = SET_REQ | CLR_REQ;
  assign req_kind  = CLR_REQ ? CLR : SET;

`ifdef DFFSR_SEQ_STAT_EN
  logic       drop;
  logic [7:0] drop_cnt_q, drop_cnt_d;
`endif

  dffsr_seq_pend u_pend (
    .clk          (CLK),
    .rst          (RST),
    .in_valid     (req_valid),
    .in_kind      (req_kind),
    .take         (take),
    .merged_valid (merged_valid),
    .merged_kind  (merged_kind)
`ifdef DFFSR_SEQ_STAT_EN
    ,
    .drop         (drop)
`endif
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    kind_d    = kind_q;
    serving_d = serving_q;
    take      = 1'b0;
    unique case (state_q)
      RST_HOLD: begin
        state_d   = RECOVER;
        cnt_d     = '0;
        serving_d = 1'b0;
      end
      IDLE: begin
        if (merged_valid) begin
          state_d   = GATE;
          kind_d    = merged_kind;
          take      = 1'b1;
          serving_d = 1'b1;
        end
      end
      GATE: begin
        state_d = PULSE;
        cnt_d   = '0;
      end
      PULSE: begin
        if (cnt_q == W_LAST) begin
          state_d = RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RECOVER: begin
        if (cnt_q == R_LAST) begin
          // Chaining straight into GATE keeps the bank clock gated between jobs.
          if (merged_valid) begin
            state_d   = GATE;
            kind_d    = merged_kind;
            take      = 1'b1;
            serving_d = 1'b1;
          end else begin
            state_d   = IDLE;
            serving_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = RST_HOLD;
    endcase
  end

  always_comb begin
    rn_d     = ~((state_d == RST_HOLD) || (state_d == PULSE && kind_d == CLR));
    sn_d     = ~(state_d == PULSE && kind_d == SET);
    clk_en_d = (state_d == IDLE);
    busy_d   = (state_d != IDLE);
    ack_d    = (state_q == RECOVER) && (cnt_q == R_LAST) && serving_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= RST_HOLD;
      cnt_q     <= '0;
      kind_q    <= SET;
      serving_q <= 1'b0;
      rn_q      <= 1'b0;
      sn_q      <= 1'b1;
      clk_en_q  <= 1'b0;
      busy_q    <= 1'b1;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      kind_q    <= kind_d;
      serving_q <= serving_d;
      rn_q      <= rn_d;
      sn_q      <= sn_d;
      clk_en_q  <= clk_en_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
    end
  end

`ifdef DFFSR_SEQ_STAT_EN
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge CLK) begin
    if (RST) drop_cnt_q <= 8'd0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign DROP_CNT = drop_cnt_q;
`endif

  assign RN     = rn_q;
  assign SN     = sn_q;
  assign CLK_EN = clk_en_q;
  assign BUSY   = busy_q;
  assign ACK    = ack_q;

endmodule

`default_nettype wire

// File: tb/tb_dffsr_ctrl_seq.sv
// ---------------------------------------------------------------------------
// Module : tb_dffsr_ctrl_seq
// Brief  : Self-checking bench for dffsr_ctrl_seq (DROP_CNT with DFFSR_SEQ_STAT_EN).
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dffsr_ctrl_seq;

  localparam int W = 2;
  localparam int R = 2;

  logic clk = 1'b0;
  logic rst, set_req, clr_req;
  logic rn, sn, clk_en, busy, ack;
`ifdef DFFSR_SEQ_STAT_EN
  logic [7:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  dffsr_ctrl_seq #(.WIDTH_CYC(W), .RECOV_CYC(R)) dut (
    .CLK     (clk),
    .RST     (rst),
    .SET_REQ (set_req),
    .CLR_REQ (clr_req),
    .RN      (rn),
    .SN      (sn),
    .CLK_EN  (clk_en),
    .BUSY    (busy),
    .ACK     (ack)
`ifdef DFFSR_SEQ_STAT_EN
    ,
    .DROP_CNT(drop_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;
  int ack_seen = 0;

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a job is a timeline indexed by its age (0 = gate cycle, then W pulse
  // cycles, then R recovery cycles); reset recovery is a countdown.
  logic m_valid = 1'b0;
  logic m_hold, m_pv, m_pk, m_jk, e_ack;
  int   m_rec, m_age, m_drops;

  always @(posedge clk) begin : model
    logic a_v, a_k, free;
    if (rst) begin
      m_valid = 1'b1; m_hold = 1'b1; m_rec = 0; m_age = -1;
      m_pv = 1'b0; m_pk = 1'b0; m_jk = 1'b0; m_drops = 0; e_ack = 1'b0;
    end else if (m_valid) begin
      a_v = set_req | clr_req;
      a_k = clr_req;
      e_ack = 1'b0;
      free = 1'b0;
      if (m_hold) begin
        m_hold = 1'b0; m_rec = R;
      end else if (m_rec > 0) begin
        m_rec--; free = (m_rec == 0);
      end else if (m_age >= 0) begin
        m_age++;
        if (m_age == 1 + W + R) begin e_ack = 1'b1; m_age = -1; free = 1'b1; end
      end else begin
        free = 1'b1;
      end
      if (a_v) begin
        if (!m_pv) begin m_pv = 1'b1; m_pk = a_k; end
        else if (!m_pk && a_k) m_pk = 1'b1;
        else if (m_drops < 255) m_drops++;
      end
      if (free && m_pv) begin m_age = 0; m_jk = m_pk; m_pv = 1'b0; end
    end
  end

  always @(negedge clk) begin : compare
    logic e_rn, e_sn, e_en, e_busy;
    if (m_valid) begin
      e_rn = 1'b1; e_sn = 1'b1; e_en = 1'b0; e_busy = 1'b1;
      if (m_hold) e_rn = 1'b0;
      else if (m_rec == 0 && m_age < 0) begin e_en = 1'b1; e_busy = 1'b0; end
      else if (m_age >= 1 && m_age <= W) begin
        if (m_jk) e_rn = 1'b0; else e_sn = 1'b0;
      end
      chk("m_rn", {8'd0, rn}, {8'd0, e_rn});
      chk("m_sn", {8'd0, sn}, {8'd0, e_sn});
      chk("m_clk_en", {8'd0, clk_en}, {8'd0, e_en});
      chk("m_busy", {8'd0, busy}, {8'd0, e_busy});
      chk("m_ack", {8'd0, ack}, {8'd0, e_ack});
      chk("rn_sn_excl", {8'd0, rn | sn}, 9'd1);
`ifdef DFFSR_SEQ_STAT_EN
      chk("m_drop_cnt", {1'b0, drop_cnt}, 9'(m_drops));
`endif
      if (ack === 1'b1) ack_seen++;
    end
  end

  task automatic req(input logic s, input logic c);
    @(posedge clk); #2; set_req = s; clr_req = c;
    @(posedge clk); #2; set_req = 1'b0; clr_req = 1'b0;
  endtask

  task automatic step(input logic s, input logic c, input logic r);
    @(posedge clk); #2; set_req = s; clr_req = c; rst = r;
  endtask

  initial begin
    int a0;
    rst = 1'b1; set_req = 1'b0; clr_req = 1'b0;

    // Reset: bank held cleared and clock gated
    repeat (3) begin
      @(posedge clk); #2; @(negedge clk);
      chk("rst_rn", {8'd0, rn}, 9'd0);
      chk("rst_clk_en", {8'd0, clk_en}, 9'd0);
      chk("rst_busy", {8'd0, busy}, 9'd1);
    end
    step(1'b0, 1'b0, 1'b0);
    @(negedge clk); chk("rel_rn_hold", {8'd0, rn}, 9'd0);
    @(negedge clk); chk("rel_rn_up", {8'd0, rn}, 9'd1);
    chk("rel_en_low", {8'd0, clk_en}, 9'd0);
    @(negedge clk); chk("rel_en_low2", {8'd0, clk_en}, 9'd0);
    @(negedge clk); chk("rel_en_up", {8'd0, clk_en}, 9'd1);
    chk("rel_busy", {8'd0, busy}, 9'd0);
    @(posedge clk); #2; chk("rel_no_ack", 9'(ack_seen), 9'd0);

    // Clear request timeline
    a0 = ack_seen;
    req(1'b0, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("clr_sn", {8'd0, sn}, 9'd1);
      case (i)
        1: chk("clr_en_t1", {8'd0, clk_en}, 9'd0);
        2: chk("clr_rn_t2", {8'd0, rn}, 9'd0);
        3: chk("clr_rn_t3", {8'd0, rn}, 9'd0);
        4: chk("clr_rn_t4", {8'd0, rn}, 9'd1);
        5: chk("clr_ack_t5", {8'd0, ack}, 9'd0);
        default: begin
          chk("clr_ack_t6", {8'd0, ack}, 9'd1);
          chk("clr_en_t6", {8'd0, clk_en}, 9'd1);
        end
      endcase
    end
    @(posedge clk); #2; chk("clr_acks", 9'(ack_seen - a0), 9'd1);

    // Simultaneous set and clear: clear wins
    a0 = ack_seen;
    req(1'b1, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("both_sn", {8'd0, sn}, 9'd1);
      if (i == 2) chk("both_rn_t2", {8'd0, rn}, 9'd0);
      if (i == 6) chk("both_ack_t6", {8'd0, ack}, 9'd1);
    end
    @(posedge clk); #2; chk("both_acks", 9'(ack_seen - a0), 9'd1);

    // Set, then set + clear arrive during pulse: clear served back-to-back
    a0 = ack_seen;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 4; i <= 11; i++) begin
      @(negedge clk);
      if (i < 11) begin
        chk("b2b_busy", {8'd0, busy}, 9'd1);
        chk("b2b_en", {8'd0, clk_en}, 9'd0);
      end
      if (i == 6) chk("b2b_ack1", {8'd0, ack}, 9'd1);
      if (i == 8) begin
        chk("b2b_rn_t8", {8'd0, rn}, 9'd0);
        chk("b2b_sn_t8", {8'd0, sn}, 9'd1);
      end
      if (i == 11) begin
        chk("b2b_ack2", {8'd0, ack}, 9'd1);
        chk("b2b_idle", {8'd0, busy}, 9'd0);
      end
    end
    @(posedge clk); #2; chk("b2b_acks", 9'(ack_seen - a0), 9'd2);

    // Reset on second pulse cycle with a pending clear
    a0 = ack_seen;
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("abort_rn", {8'd0, rn}, 9'd0);
    chk("abort_sn", {8'd0, sn}, 9'd1);
    chk("abort_en", {8'd0, clk_en}, 9'd0);
    for (int i = 5; i <= 12; i++) begin
      @(negedge clk);
      chk("abort_rn_idle", {8'd0, rn}, 9'd1);
      chk("abort_no_ack", {8'd0, ack}, 9'd0);
      if (i >= 7) chk("abort_idle", {8'd0, busy}, 9'd0);
    end
    @(posedge clk); #2; chk("abort_acks", 9'(ack_seen - a0), 9'd0);

`ifdef DFFSR_SEQ_STAT_EN
    // Continuous set requests overflow the slot; counter saturates
    step(1'b1, 1'b0, 1'b0);
    repeat (500) @(posedge clk);
    #2; set_req = 1'b0;
    repeat (10) @(negedge clk);
    chk("drop_sat", {1'b0, drop_cnt}, 9'd255);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("drop_clr", {1'b0, drop_cnt}, 9'd0);
    repeat (5) @(negedge clk);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
